i2s_msb_slave_receiver: RTL and testbench

I2S slave-side capture block. It accepts an externally clocked MSB-justified 8-slot stream (bit clock, LR clock and data, all driven by an off-chip master), synchronises it into the `clk_i` domain, and writes every received bit into a `channel_buffer`. The buffer is a circular store of 2^CIRC_BUF_BITS frames of 256 bits. It is the counterpart to `i2s_msb_transmitter`: it receives the stream that block drives when the transmitter runs as bus master.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_msb_slave_receiver_sync.sv | 37 +++
 rtl/i2s_msb_slave_receiver.sv | 129 ++++++++++++
 tb/tb_i2s_msb_slave_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: frame geometry and FSM state shared by the I2S MSB-justified transmitter and receiver.
package i2s_pkg;
    localparam int FRAME_BITS = 256;
    localparam int SLOT_BITS  = 32;
    localparam int SLOTS      = 8;
    localparam int LR_HALF    = 128;

    typedef enum logic {SEEK = 1'b0, RUN = 1'b1} i2s_state_e;

    // lrclk is high for the first half of the frame, low for the second
    function automatic logic lr_expected(input logic [7:0] bit_cnt);
        return bit_cnt < 8'(LR_HALF);
    endfunction
endpackage

// File: rtl/i2s_msb_slave_receiver_sync.sv
// i2s_input_sync: 2-FF synchroniser for bclk/lrclk/data plus bclk rising-edge detect.
module i2s_input_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bclk_i,
    input  logic lrclk_i,
    input  logic data_i,
    output logic bclk_rise,
    output logic lrclk_s,
    output logic data_s
);
    logic [2:0] meta_q, meta_d, sync_q, sync_d;
    logic       bclk_prev_q, bclk_prev_d;

    always_comb begin
        meta_d      = {data_i, lrclk_i, bclk_i};
        sync_d      = meta_q;
        bclk_prev_d = sync_q[0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q      <= '0;
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            bclk_prev_q <= bclk_prev_d;
        end
    end

    // lrclk and data come from the same stage as the detected edge
    assign bclk_rise = sync_q[0] & ~bclk_prev_q;
    assign lrclk_s   = sync_q[1];
    assign data_s    = sync_q[2];
endmodule

// File: rtl/i2s_msb_slave_receiver.sv
// i2s_msb_slave_receiver: captures an externally clocked MSB-justified 8-slot I2S stream
// into a circular buffer of 256-bit frames, with lrclk framing checks and bclk timeout.
module i2s_msb_slave_receiver
    import i2s_pkg::*;
#(
    parameter int CIRC_BUF_BITS = 3,
    parameter int BCLK_TIMEOUT  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i2s_bclk_i,
    input  logic                     i2s_lrclk_i,
    input  logic                     i2s_data_i,
    output logic [CIRC_BUF_BITS+7:0] ram_write_addr_o,
    output logic                     ram_write_en_o,
    output logic                     ram_write_data_o,
    output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
    output logic                     frame_done_o,
    output logic                     locked_o,
    output logic                     sync_err_o
);
    localparam int IW = $clog2(BCLK_TIMEOUT + 1);

    logic bclk_rise, lrclk_s, data_s;
    logic lr_ok, start, timeout;

    i2s_state_e               state_q, state_d;
    logic [7:0]               bit_cnt_q, bit_cnt_d;
    logic [CIRC_BUF_BITS-1:0] frame_idx_q, frame_idx_d, last_good_q, last_good_d;
    logic [IW-1:0]            idle_q, idle_d;
    logic                     lr_prev_q, lr_prev_d;
    logic [CIRC_BUF_BITS+7:0] wr_addr_q, wr_addr_d;
    logic                     wr_en_q, wr_en_d, wr_data_q, wr_data_d;
    logic                     frame_done_q, frame_done_d, sync_err_q, sync_err_d;

    i2s_input_sync u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bclk_i    (i2s_bclk_i),
        .lrclk_i   (i2s_lrclk_i),
        .data_i    (i2s_data_i),
        .bclk_rise (bclk_rise),
        .lrclk_s   (lrclk_s),
        .data_s    (data_s)
    );

    assign lr_ok   = lrclk_s == lr_expected(bit_cnt_q);
    assign start   = bclk_rise && lrclk_s && !lr_prev_q;
    // an edge in the same cycle as expiry wins
    assign timeout = !bclk_rise && idle_q == IW'(BCLK_TIMEOUT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= SEEK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == SEEK && start)
            state_d = RUN;
        else if (state_q == RUN && ((bclk_rise && !lr_ok) || timeout))
            state_d = SEEK;
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        frame_idx_d  = frame_idx_q;
        last_good_d  = last_good_q;
        lr_prev_d    = bclk_rise ? lrclk_s : lr_prev_q;
        idle_d       = bclk_rise ? '0 : (idle_q == IW'(BCLK_TIMEOUT) ? idle_q : idle_q + 1'b1);
        wr_en_d      = 1'b0;
        wr_addr_d    = {frame_idx_q, bit_cnt_q};
        wr_data_d    = data_s;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (state_q == SEEK) begin
            if (start) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {frame_idx_q, 8'd0};
                bit_cnt_d = 8'd1;
            end
        end else if (bclk_rise && lr_ok) begin
            wr_en_d   = 1'b1;
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'(FRAME_BITS - 1)) begin
                frame_done_d = 1'b1;
                last_good_d  = frame_idx_q;
                frame_idx_d  = frame_idx_q + 1'b1;
            end
        end else if (bclk_rise || timeout) begin
            sync_err_d = 1'b1;
            bit_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q    <= '0;
            frame_idx_q  <= '0;
            last_good_q  <= '0;
            idle_q       <= '0;
            lr_prev_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            frame_idx_q  <= frame_idx_d;
            last_good_q  <= last_good_d;
            idle_q       <= idle_d;
            lr_prev_q    <= lr_prev_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ram_write_addr_o      = wr_addr_q;
    assign ram_write_en_o        = wr_en_q;
    assign ram_write_data_o      = wr_data_q;
    assign last_good_frame_idx_o = last_good_q;
    assign frame_done_o          = frame_done_q;
    assign sync_err_o            = sync_err_q;
    assign locked_o              = state_q == RUN;
endmodule

// File: tb/tb_i2s_msb_slave_receiver.sv
// tb_i2s_msb_slave_receiver: random-data I2S stream with a frame-level reference model;
// expected writes/frame completions/errors are queued and popped by an output monitor.
module tb_i2s_msb_slave_receiver;
    localparam int CB = 3;

    logic clk = 1'b0, rst = 1'b1, bclk = 1'b0, lrclk = 1'b0, data = 1'b0;
    logic [CB+7:0] waddr;
    logic          wen, wdata, fdone, locked, serr;
    logic [CB-1:0] lgood;

    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    i2s_msb_slave_receiver #(.CIRC_BUF_BITS(CB), .BCLK_TIMEOUT(64)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .i2s_bclk_i            (bclk),
        .i2s_lrclk_i           (lrclk),
        .i2s_data_i            (data),
        .ram_write_addr_o      (waddr),
        .ram_write_en_o        (wen),
        .ram_write_data_o      (wdata),
        .last_good_frame_idx_o (lgood),
        .frame_done_o          (fdone),
        .locked_o              (locked),
        .sync_err_o            (serr)
    );

    // scoreboard queues
    logic [CB+7:0] wa_q[$];
    bit            wd_q[$];
    logic [CB-1:0] fd_q[$];
    int            err_exp = 0;

    // reference model: lock state, position in frame, buffer slot, last completed slot
    bit            m_locked = 1'b0, m_prev = 1'b0;
    logic [7:0]    m_pos = '0;
    logic [CB-1:0] m_fidx = '0, m_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic ref_edge(input bit lr, input bit d);
        bit wr = 1'b0;
        if (!m_locked) begin
            if (lr && !m_prev) begin
                m_locked = 1'b1;
                m_pos    = '0;
                wr       = 1'b1;
            end
        end else if (lr == (m_pos < 8'd128)) begin
            wr = 1'b1;
        end else begin
            m_locked = 1'b0;
            m_pos    = '0;
            err_exp++;
        end
        if (wr) begin
            wa_q.push_back({m_fidx, m_pos});
            wd_q.push_back(d);
            if (m_pos == 8'd255) begin
                fd_q.push_back(m_fidx);
                m_last = m_fidx;
                m_fidx = m_fidx + 1'b1;
            end
            m_pos = m_pos + 8'd1;
        end
        m_prev = lr;
    endtask

    // one bclk period (8 clk): data/lrclk change with bclk low, sampled on the rise
    task automatic send_bit(input bit lr, input bit d, input bit lat);
        bclk  = 1'b0;
        lrclk = lr;
        data  = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        ref_edge(lr, d);
        if (lat) begin
            @(posedge clk);
            @(posedge clk); #1 check("latency_e1_low", wen, 0);
            @(posedge clk); #1 check("latency_e2_high", wen, 1);
            repeat (4) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_range(input int from, input int to, input bit lat);
        for (int p = from; p <= to; p++)
            send_bit(p < 128, 1'($urandom), lat && p == from);
    endtask

    task automatic idle(input int n);
        bclk = 1'b0;
        if (m_locked) begin
            m_locked = 1'b0;
            m_pos    = '0;
            err_exp++;
        end
        repeat (n) @(negedge clk);
    endtask

    // monitor
    bit            pend_lg = 1'b0, first_seen = 1'b0;
    logic [CB-1:0] exp_lg;

    always @(negedge clk) begin
        if (!rst) begin
            if (pend_lg) begin
                check("last_good_idx", lgood, exp_lg);
                pend_lg = 1'b0;
            end
            if (wen) begin
                check("write_expected", wa_q.size() != 0, 1);
                if (!first_seen) begin
                    check("first_write_addr", waddr, 0);
                    first_seen = 1'b1;
                end
                if (wa_q.size() != 0) begin
                    check("write_addr", waddr, wa_q.pop_front());
                    check("write_data", wdata, wd_q.pop_front());
                end
                check("locked_on_write", locked, 1);
            end
            if (fdone) begin
                check("frame_done_expected", fd_q.size() != 0, 1);
                check("frame_done_on_bit255", {wen, waddr[7:0]}, {1'b1, 8'hFF});
                if (fd_q.size() != 0) begin
                    exp_lg  = fd_q.pop_front();
                    pend_lg = 1'b1;
                end
            end
            if (serr) begin
                check("sync_err_expected", err_exp > 0, 1);
                if (err_exp > 0) err_exp--;
                check("unlocked_on_err", locked, 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {wen, wdata, waddr, lgood, fdone, locked, serr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // join mid-frame with lrclk low: nothing written until the 0->1 transition
        send_range(150, 255, 0);
        check("no_lock_midframe", locked, 0);
        // clean frames, enough to wrap the 8-entry buffer
        send_range(0, 255, 1);
        for (int f = 1; f < 12; f++) send_range(0, 255, 0);
        // lrclk drops early at bit 100
        send_range(0, 99, 0);
        send_bit(1'b0, 1'($urandom), 0);
        check("unlocked_after_lr_err", locked, 0);
        check("last_good_held_lr_err", lgood, m_last);
        send_range(0, 255, 0);
        // bclk stalls mid-frame, restart without an lrclk rising edge
        send_range(0, 49, 0);
        idle(70);
        check("unlocked_after_timeout", locked, 0);
        check("last_good_held_timeout", lgood, m_last);
        send_range(50, 255, 0);
        send_range(0, 255, 0);
        // reset at bit 200
        send_range(0, 199, 0);
        rst = 1'b1;
        #1 check("reset_midframe_outputs", {wen, wdata, waddr, lgood, fdone, locked, serr}, 0);
        m_locked = 1'b0;
        m_prev   = 1'b0;
        m_pos    = '0;
        m_fidx   = '0;
        pend_lg  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_range(200, 255, 0);
        send_range(0, 255, 0);
        repeat (20) @(negedge clk);
        check("last_good_after_reset", lgood, 0);
        check("writes_drained", wa_q.size(), 0);
        check("frame_done_drained", fd_q.size(), 0);
        check("errors_drained", err_exp, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
